// File: rtl/adc_capture_if.sv
// ADC capture bus: runtime configuration, raw ADC pins and processed sample stream.
// The controller side (master) drives configuration and ADC data; adc_capture is the slave.
interface adc_capture_if #(
  parameter int pDataBits = 8,
  parameter int pDivBits  = 16
);
  logic                 iEnable;
  logic [pDivBits-1:0]  iHalfPeriod;
  logic [3:0]           iDecLog2;
  logic [1:0]           iMode;
  logic [pDataBits-1:0] iADC_Data;
  logic [pDataBits-1:0] oADC_Data;
  logic                 oData_Valid;
  logic                 oADC_CLK;
  logic                 oADC_nOE;

  modport master (
    output iEnable, iHalfPeriod, iDecLog2, iMode, iADC_Data,
    input  oADC_Data, oData_Valid, oADC_CLK, oADC_nOE
  );

  modport slave (
    input  iEnable, iHalfPeriod, iDecLog2, iMode, iADC_Data,
    output oADC_Data, oData_Valid, oADC_CLK, oADC_nOE
  );
endinterface

// File: rtl/adc_capture.sv
// ADC front end: divided ADC clock, falling-edge capture, and power-of-two
// group reduction (decimate / average / min / max) with a one-cycle valid strobe.
module adc_capture #(
  parameter int pDataBits   = 8,
  parameter int pDivBits    = 16,
  parameter int pDecLog2Max = 8
) (
  input  logic          iClk,
  input  logic          iRst,
  adc_capture_if.slave  bus
);
  localparam int ACCW = pDataBits + pDecLog2Max;
  localparam logic [3:0] LMAX = 4'(pDecLog2Max);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                 r_state;
  logic [pDivBits-1:0]    r_cnt;
  logic [pDivBits-1:0]    r_half;
  logic                   r_clk;
  logic                   r_noe;
  logic [pDataBits-1:0]   r_raw;
  logic                   r_raw_stb;
  logic [pDecLog2Max-1:0] r_grp;
  logic [3:0]             r_L;
  logic [1:0]             r_mode;
  logic [ACCW-1:0]        r_acc;
  logic [pDataBits-1:0]   r_min;
  logic [pDataBits-1:0]   r_max;
  logic [pDataBits-1:0]   r_first;
  logic [pDataBits-1:0]   r_data;
  logic                   r_valid;

  logic [pDivBits-1:0]    w_half_in;
  logic [pDivBits-1:0]    w_half;
  logic                   w_wrap;
  logic                   w_grp0;
  logic [3:0]             w_L;
  logic [1:0]             w_mode;
  logic [pDecLog2Max-1:0] w_grp_last;
  logic                   w_last;
  logic [ACCW-1:0]        w_sum;
  logic [pDataBits-1:0]   w_min;
  logic [pDataBits-1:0]   w_max;
  logic [pDataBits-1:0]   w_first;
  logic [pDataBits-1:0]   w_result;

  // The half-period in force is latched at each toggle; before the first
  // enabled edge the live input is used so the very first half-period obeys it.
  always_comb begin
    w_half_in = (bus.iHalfPeriod == '0) ? pDivBits'(1) : bus.iHalfPeriod;
    w_half    = (r_state == ST_RUN) ? r_half : w_half_in;
    w_wrap    = (r_cnt == (w_half - pDivBits'(1)));
  end

  // Group parameters come live from the inputs on the first sample, then from
  // the latched copies for the remainder of the group.
  always_comb begin
    w_grp0 = (r_grp == '0);
    if (w_grp0) begin
      w_L    = (bus.iDecLog2 > LMAX) ? LMAX : bus.iDecLog2;
      w_mode = bus.iMode;
    end else begin
      w_L    = r_L;
      w_mode = r_mode;
    end
    w_grp_last = '0;
    for (int unsigned i = 0; i < pDecLog2Max; i++) begin
      if (i < 32'(w_L)) w_grp_last[i] = 1'b1;
    end
    w_last = (r_grp == w_grp_last);
  end

  always_comb begin
    w_sum   = w_grp0 ? ACCW'(r_raw) : (r_acc + ACCW'(r_raw));
    w_min   = (w_grp0 || (r_raw < r_min)) ? r_raw : r_min;
    w_max   = (w_grp0 || (r_raw > r_max)) ? r_raw : r_max;
    w_first = w_grp0 ? r_raw : r_first;
    case (w_mode)
      2'd0:    w_result = w_first;
      2'd1:    w_result = pDataBits'(w_sum >> w_L);
      2'd2:    w_result = w_min;
      default: w_result = w_max;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_half    <= '0;
      r_clk     <= 1'b0;
      r_noe     <= 1'b1;
      r_raw     <= '0;
      r_raw_stb <= 1'b0;
      r_grp     <= '0;
      r_L       <= '0;
      r_mode    <= '0;
      r_acc     <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_first   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else if (!bus.iEnable) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_half    <= '0;
      r_clk     <= 1'b0;
      r_noe     <= 1'b1;
      r_raw     <= '0;
      r_raw_stb <= 1'b0;
      r_grp     <= '0;
      r_L       <= '0;
      r_mode    <= '0;
      r_acc     <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_first   <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= ST_RUN;
      r_noe     <= 1'b0;
      r_raw_stb <= 1'b0;
      r_valid   <= 1'b0;
      if (w_wrap) begin
        r_cnt  <= '0;
        r_clk  <= ~r_clk;
        r_half <= w_half_in;
        if (r_clk) begin
          r_raw     <= bus.iADC_Data;
          r_raw_stb <= 1'b1;
        end
      end else begin
        r_cnt  <= r_cnt + pDivBits'(1);
        r_half <= w_half;
      end
      if (r_raw_stb) begin
        r_acc   <= w_sum;
        r_min   <= w_min;
        r_max   <= w_max;
        r_first <= w_first;
        r_L     <= w_L;
        r_mode  <= w_mode;
        if (w_last) begin
          r_grp   <= '0;
          r_data  <= w_result;
          r_valid <= 1'b1;
        end else begin
          r_grp <= r_grp + pDecLog2Max'(1);
        end
      end
    end
  end

  assign bus.oADC_Data   = r_data;
  assign bus.oData_Valid = r_valid;
  assign bus.oADC_CLK    = r_clk;
  assign bus.oADC_nOE    = r_noe;
endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: clock divider, capture latency, the four
// reduction modes, clamping, enable/reset discards and runtime reconfiguration.
module tb_adc_capture;
  logic clk;
  logic rst;

  adc_capture_if #(.pDataBits(8), .pDivBits(16)) bus ();

  adc_capture #(.pDataBits(8), .pDivBits(16), .pDecLog2Max(8)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         npass = 0;
  int         ntotal = 0;
  int         cyc;
  int         sidx;
  logic       prev_clk;
  logic [7:0] samp [0:15];
  logic [63:0] trace;
  int         vcyc[$];
  logic [7:0] vdat[$];

  // Advances n clock edges, sampling 1 ns after each edge; ADC data moves to
  // the next sample right after each observed ADC clock falling edge.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < 64) trace[cyc] = bus.oADC_CLK;
      if (bus.oData_Valid === 1'b1) begin
        vcyc.push_back(cyc);
        vdat.push_back(bus.oADC_Data);
      end
      if (prev_clk && !bus.oADC_CLK && sidx < 15) begin
        sidx++;
        bus.iADC_Data = samp[sidx];
      end
      prev_clk = bus.oADC_CLK;
    end
  endtask

  task automatic start_capture(input int h, input int l, input int m);
    bus.iEnable = 1'b0;
    @(posedge clk);
    #1;
    bus.iHalfPeriod = 16'(h);
    bus.iDecLog2    = 4'(l);
    bus.iMode       = 2'(m);
    sidx = 0;
    bus.iADC_Data = samp[0];
    prev_clk = 1'b0;
    cyc = 0;
    trace = '0;
    vcyc.delete();
    vdat.delete();
    bus.iEnable = 1'b1;
  endtask

  task automatic clear_samples();
    for (int i = 0; i < 16; i++) samp[i] = 8'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iEnable = 1'b0;
    bus.iHalfPeriod = 16'd5;
    bus.iDecLog2 = 4'd0;
    bus.iMode = 2'd0;
    bus.iADC_Data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    ntotal++; if (bus.oADC_CLK !== 1'b0) $display("FAIL reset_clk got %b want 0", bus.oADC_CLK); else npass++;
    ntotal++; if (bus.oADC_nOE !== 1'b1) $display("FAIL reset_noe got %b want 1", bus.oADC_nOE); else npass++;
    ntotal++; if (bus.oADC_Data !== 8'd0) $display("FAIL reset_data got %0d want 0", bus.oADC_Data); else npass++;
    ntotal++; if (bus.oData_Valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.oData_Valid); else npass++;
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    logic [63:0] exp_tr;
    clear_samples();
    for (int i = 0; i < 16; i++) samp[i] = 8'(8'h10 + i);
    start_capture(5, 0, 0);
    run_cycles(40);
    exp_tr = '0;
    for (int k = 1; k <= 40; k++) exp_tr[k] = ((k / 5) % 2) == 1;
    ntotal++; if (trace[40:1] !== exp_tr[40:1]) $display("FAIL ramp_clk_trace got %h want %h", trace[40:1], exp_tr[40:1]); else npass++;
    ntotal++; if (bus.oADC_nOE !== 1'b0) $display("FAIL ramp_noe got %b want 0", bus.oADC_nOE); else npass++;
    ntotal++; if (vcyc.size() != 3) $display("FAIL ramp_valid_count got %0d want 3", vcyc.size()); else npass++;
    for (int i = 0; i < vcyc.size() && i < 3; i++) begin
      ntotal++; if (vcyc[i] != 11 + 10 * i) $display("FAIL ramp_valid_cycle[%0d] got %0d want %0d", i, vcyc[i], 11 + 10 * i); else npass++;
      ntotal++; if (vdat[i] !== samp[i]) $display("FAIL ramp_data[%0d] got %0d want %0d", i, vdat[i], samp[i]); else npass++;
    end
  endtask

  task automatic test_zero_half();
    clear_samples();
    samp[0] = 8'd77;
    start_capture(0, 0, 0);
    run_cycles(4);
    ntotal++; if (trace[4:1] !== 4'b0101) $display("FAIL zero_half_trace got %b want 0101", trace[4:1]); else npass++;
    ntotal++; if (vcyc.size() < 1 || vcyc[0] != 3 || vdat[0] !== 8'd77)
      $display("FAIL zero_half_first_valid got n=%0d cyc=%0d want cyc=3 data=77", vcyc.size(), (vcyc.size() > 0) ? vcyc[0] : -1);
    else npass++;
  endtask

  task automatic test_average();
    clear_samples();
    samp[0] = 8'd10; samp[1] = 8'd20; samp[2] = 8'd30; samp[3] = 8'd41;
    samp[4] = 8'd50; samp[5] = 8'd60; samp[6] = 8'd70; samp[7] = 8'd80;
    start_capture(2, 2, 1);
    run_cycles(36);
    ntotal++; if (vcyc.size() != 2) $display("FAIL avg_valid_count got %0d want 2", vcyc.size()); else npass++;
    if (vcyc.size() >= 2) begin
      ntotal++; if (vcyc[0] != 17) $display("FAIL avg_first_cycle got %0d want 17", vcyc[0]); else npass++;
      ntotal++; if (vdat[0] !== 8'd25) $display("FAIL avg_first_data got %0d want 25", vdat[0]); else npass++;
      ntotal++; if (vcyc[1] - vcyc[0] != 16) $display("FAIL avg_spacing got %0d want 16", vcyc[1] - vcyc[0]); else npass++;
      ntotal++; if (vdat[1] !== 8'd65) $display("FAIL avg_second_data got %0d want 65", vdat[1]); else npass++;
    end
  endtask

  task automatic test_minmax();
    int         modes [3] = '{2, 3, 0};
    logic [7:0] expv  [3] = '{8'd0, 8'd255, 8'd7};
    clear_samples();
    samp[0] = 8'd7; samp[1] = 8'd200; samp[2] = 8'd3;   samp[3] = 8'd255;
    samp[4] = 8'd0; samp[5] = 8'd9;   samp[6] = 8'd128; samp[7] = 8'd64;
    for (int j = 0; j < 3; j++) begin
      start_capture(1, 3, modes[j]);
      run_cycles(20);
      ntotal++;
      if (vcyc.size() != 1 || vcyc[0] != 17 || vdat[0] !== expv[j])
        $display("FAIL minmax_mode%0d got n=%0d cyc=%0d data=%0d want n=1 cyc=17 data=%0d", modes[j],
                 vcyc.size(), (vcyc.size() > 0) ? vcyc[0] : -1, (vdat.size() > 0) ? vdat[0] : 8'hxx, expv[j]);
      else npass++;
    end
  endtask

  task automatic test_long_group();
    int dls [2] = '{8, 15};
    for (int i = 0; i < 16; i++) samp[i] = 8'd255;
    for (int j = 0; j < 2; j++) begin
      start_capture(1, dls[j], 1);
      run_cycles(520);
      ntotal++;
      if (vcyc.size() != 1 || vcyc[0] != 513 || vdat[0] !== 8'd255)
        $display("FAIL long_dec%0d got n=%0d cyc=%0d data=%0d want n=1 cyc=513 data=255", dls[j],
                 vcyc.size(), (vcyc.size() > 0) ? vcyc[0] : -1, (vdat.size() > 0) ? vdat[0] : 8'hxx);
      else npass++;
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 16; i++) samp[i] = 8'd100;
    start_capture(1, 2, 1);
    run_cycles(5);
    bus.iEnable = 1'b0;
    run_cycles(1);
    ntotal++; if (vcyc.size() != 0) $display("FAIL drop_partial_valid got %0d valids want 0", vcyc.size()); else npass++;
    ntotal++; if (bus.oADC_CLK !== 1'b0) $display("FAIL drop_clk got %b want 0", bus.oADC_CLK); else npass++;
    ntotal++; if (bus.oADC_nOE !== 1'b1) $display("FAIL drop_noe got %b want 1", bus.oADC_nOE); else npass++;
    ntotal++; if (bus.oADC_Data !== 8'd255) $display("FAIL drop_hold_data got %0d want 255", bus.oADC_Data); else npass++;

    clear_samples();
    samp[0] = 8'd4; samp[1] = 8'd8; samp[2] = 8'd12; samp[3] = 8'd16;
    start_capture(1, 2, 1);
    run_cycles(12);
    ntotal++;
    if (vcyc.size() != 1 || vcyc[0] != 9 || vdat[0] !== 8'd10)
      $display("FAIL reenable_avg got n=%0d cyc=%0d data=%0d want n=1 cyc=9 data=10",
               vcyc.size(), (vcyc.size() > 0) ? vcyc[0] : -1, (vdat.size() > 0) ? vdat[0] : 8'hxx);
    else npass++;

    // Drop enable just before the edge that would carry a valid.
    for (int i = 0; i < 16; i++) samp[i] = 8'h33;
    start_capture(1, 0, 0);
    run_cycles(2);
    bus.iEnable = 1'b0;
    run_cycles(1);
    ntotal++; if (vcyc.size() != 0 || bus.oData_Valid !== 1'b0) $display("FAIL drop_landing_valid got n=%0d valid=%b want 0", vcyc.size(), bus.oData_Valid); else npass++;
    ntotal++; if (bus.oADC_Data !== 8'd10) $display("FAIL drop_landing_hold got %0d want 10", bus.oADC_Data); else npass++;
  endtask

  task automatic test_async_reset();
    clear_samples();
    start_capture(5, 0, 0);
    run_cycles(7);
    #2;
    rst = 1'b1;
    #1;
    ntotal++; if (bus.oADC_CLK !== 1'b0) $display("FAIL async_rst_clk got %b want 0", bus.oADC_CLK); else npass++;
    ntotal++; if (bus.oADC_nOE !== 1'b1) $display("FAIL async_rst_noe got %b want 1", bus.oADC_nOE); else npass++;
    ntotal++; if (bus.oADC_Data !== 8'd0) $display("FAIL async_rst_data got %0d want 0", bus.oADC_Data); else npass++;
    #1;
    rst = 1'b0;
    bus.iEnable = 1'b0;
  endtask

  task automatic test_halfperiod_change();
    logic [63:0] exp_tr;
    clear_samples();
    start_capture(5, 0, 0);
    run_cycles(6);
    bus.iHalfPeriod = 16'd3;
    run_cycles(14);
    exp_tr = '0;
    exp_tr[9:5] = 5'b11111;
    exp_tr[15:13] = 3'b111;
    exp_tr[20:19] = 2'b11;
    ntotal++; if (trace[20:1] !== exp_tr[20:1]) $display("FAIL halfperiod_trace got %h want %h", trace[20:1], exp_tr[20:1]); else npass++;
  endtask

  task automatic test_mode_change();
    clear_samples();
    samp[0] = 8'd5; samp[1] = 8'd9; samp[2] = 8'd3; samp[3] = 8'd7;
    samp[4] = 8'd6; samp[5] = 8'd2; samp[6] = 8'd8; samp[7] = 8'd4;
    start_capture(1, 2, 2);
    run_cycles(5);
    bus.iMode = 2'd3;
    run_cycles(14);
    ntotal++; if (vcyc.size() != 2) $display("FAIL modechg_count got %0d want 2", vcyc.size()); else npass++;
    if (vcyc.size() >= 2) begin
      ntotal++; if (vcyc[0] != 9 || vdat[0] !== 8'd3) $display("FAIL modechg_group1 got cyc=%0d data=%0d want cyc=9 data=3", vcyc[0], vdat[0]); else npass++;
      ntotal++; if (vcyc[1] != 17 || vdat[1] !== 8'd8) $display("FAIL modechg_group2 got cyc=%0d data=%0d want cyc=17 data=8", vcyc[1], vdat[1]); else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_zero_half();
    test_average();
    test_minmax();
    test_long_group();
    test_enable_drop();
    test_async_reset();
    test_halfperiod_change();
    test_mode_change();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
- Parametrised successor to the fixed 10 MHz, 8-bit ADC front end.
- Generates the ADC clock from iClk with a runtime divider and captures ADC data on the ADC clock falling edge.
- Reduces the raw sample stream by a runtime power-of-two factor in one of four modes: decimate, average, min, max (peak detect).
- Feeds the scope sample buffer with one single-cycle oData_Valid pulse per output sample.

Parameters:
- pDataBits, 8: ADC sample width.
- pDivBits, 16: width of the half-period divider.
- pDecLog2Max, 8: maximum log2 decimation factor. The accumulator is pDataBits+pDecLog2Max bits.

Ports:
- iClk, in, 1: system clock (100 MHz).
- iRst, in, 1: asynchronous active-high reset.
- iEnable, in, 1: capture enable.
- iHalfPeriod, in, pDivBits: iClk cycles per ADC clock half-period; 0 is treated as 1.
- iDecLog2, in, 4: log2 of samples per output; values above pDecLog2Max clamp to pDecLog2Max.
- iMode, in, 2: 0 = decimate (keep first sample of group), 1 = average, 2 = min, 3 = max.
- iADC_Data, in, pDataBits: ADC parallel data, unsigned.
- oADC_Data, out, pDataBits: processed output sample.
- oData_Valid, out, 1: one-cycle strobe qualifying oADC_Data.
- oADC_CLK, out, 1: ADC clock.
- oADC_nOE, out, 1: ADC output enable, active low.

Behaviour:
- Reset: iRst is asynchronous and active-high. All state clears immediately.
  - oADC_CLK=0, oADC_nOE=1, oADC_Data=0, oData_Valid=0.
  - Divider, group counter and accumulator/min/max registers are 0.
- Reset mid-group discards the partial group; no valid is emitted for it.
- Disabled (iEnable=0): same state as reset except oADC_Data holds its last value. oADC_nOE=1.
- Enabled: oADC_nOE=0.
- Divider:
  - The counter runs 0..H-1, where H=max(iHalfPeriod,1).
  - At count H-1 the counter wraps to 0 and oADC_CLK toggles.
  - ADC clock period is 2H iClk cycles.
  - The first enabled edge loads count 0, so oADC_CLK rises after edge H and falls after edge 2H.
  - iHalfPeriod is re-read at every toggle; a change affects the next half-period only.
- Capture: on the edge where oADC_CLK goes 1->0, iADC_Data is registered into a raw register and an internal raw strobe pulses for 1 cycle.
- Group start: when the group counter is 0, L=min(iDecLog2,pDecLog2Max) and iMode are latched. Changes mid-group are ignored until the next group.
- Processing, one cycle after the raw strobe:
  - First sample of a group: acc=raw, min=raw, max=raw, first=raw.
  - Later samples: acc+=raw (zero-extended), min=min(raw), max=max(raw). Compares are unsigned.
  - The group counter increments and wraps at 2^L-1.
- Output, on the processing cycle of the last sample in the group:
  - oADC_Data is the mode result, including that sample: first / acc>>L (truncating) / min / max.
  - oData_Valid=1 for exactly that cycle.
- Latency:
  - L=0: oData_Valid is high in the cycle after edge 2H+1.
  - General case: the first valid follows edge 2H*2^L+1; thereafter one valid every 2H*2^L cycles.
- L=0 makes all modes equal to pass-through.
- Accumulator never overflows: max sum is 2^L*(2^pDataBits-1), which fits in pDataBits+pDecLog2Max bits.
- Enable deasserted mid-group: the partial group is discarded and oADC_CLK is forced to 0 on the next edge. No valid is emitted, including one that would have landed that cycle.
- Re-enable restarts from count 0 with a new group.
- Defaults H=5, L=0 reproduce the existing 10 MHz, 8-bit behaviour.

Test Plan:
- Reset then iEnable=1, H=5, L=0, mode 0, iADC_Data ramping +1 per ADC clock: oADC_CLK is a 10-cycle square wave; first valid 11 cycles after enable; valid every 10 cycles carrying the falling-edge values; nOE=0.
- H=2, L=2, mode 1, ADC samples 10, 20, 30, 41: one valid with oADC_Data=25 (101>>2); 16 cycles between valids.
- H=1, L=3, modes 2 and 3, samples 7, 200, 3, 255, 0, 9, 128, 64: min=0, max=255. Mode 0 gives 7.
- L=8, mode 1, iADC_Data=255 constant: oADC_Data=255 with no overflow. iDecLog2=15 behaves identically to 8 (clamp).
- Mid-group iEnable drop after 2 of 4 samples, then re-enable: no valid for the partial group; the next valid averages only the 4 post-enable samples. iRst pulse mid-period gives oADC_CLK=0 and nOE=1 immediately (asynchronous).
- iHalfPeriod changed 5->3 while oADC_CLK is high: the current half-period completes at 5; subsequent half-periods are 3. iMode changed mid-group takes effect from the next group only.
